// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between instruction fetch and
// the load/store data port. Data side has priority; a starvation counter
// forces a fetch grant after STARVE_MAX consecutive data grants with fetch waiting.
// Ports: clk/reset (sync, active-high); imem_* fetch read port; dmem_* load/store
// port; mem_* registered request/ack memory port; busy = transaction in flight.
// Latency: grant cycle + >=1 busy cycle + 1 response cycle (ready pulse).
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] imem_rd_addr,
  input  logic              imem_rd_enable,
  output logic [DATA_W-1:0] imem_rd_data,
  output logic              imem_ready,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic              dmem_r_enable,
  input  logic              dmem_w_enable,
  input  logic [1:0]        dmem_w_size,
  input  logic [DATA_W-1:0] dmem_w_data,
  output logic [DATA_W-1:0] dmem_r_data,
  output logic              dmem_ready,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [1:0]        mem_size,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     state, state_nxt;
  logic [3:0] starve_cnt;
  logic       data_req;
  logic       fetch_wins;
  logic       grant_i;
  logic       grant_d;
  logic       in_busy;

  assign data_req   = dmem_r_enable | dmem_w_enable;
  // Fetch wins when it is alone, or when the data side has used up its quota.
  assign fetch_wins = imem_rd_enable & (~data_req | (starve_cnt == STARVE_LIM));
  assign grant_i    = (state == IDLE) & fetch_wins;
  assign grant_d    = (state == IDLE) & data_req & ~fetch_wins;
  assign in_busy    = (state == BUSY_I) | (state == BUSY_D);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_i)      state_nxt = BUSY_I;
        else if (grant_d) state_nxt = BUSY_D;
      end
      BUSY_I, BUSY_D: begin
        if (mem_ack) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req      <= 1'b0;
      mem_addr     <= '0;
      mem_we       <= 1'b0;
      mem_size     <= 2'd0;
      mem_wdata    <= '0;
      imem_rd_data <= '0;
      dmem_r_data  <= '0;
      imem_ready   <= 1'b0;
      dmem_ready   <= 1'b0;
      starve_cnt   <= 4'd0;
    end else begin
      imem_ready <= 1'b0;
      dmem_ready <= 1'b0;

      if (grant_i) begin
        mem_req    <= 1'b1;
        mem_addr   <= imem_rd_addr;
        mem_we     <= 1'b0;
        mem_size   <= 2'd2;
        mem_wdata  <= '0;
        starve_cnt <= 4'd0;
      end else if (grant_d) begin
        mem_req   <= 1'b1;
        mem_addr  <= dmem_addr;
        // Simultaneous read+write: the write wins, no read is performed.
        mem_we    <= dmem_w_enable;
        mem_size  <= dmem_w_size;
        mem_wdata <= dmem_w_data;
        if (!imem_rd_enable)
          starve_cnt <= 4'd0;
        else if (starve_cnt != STARVE_LIM)
          starve_cnt <= starve_cnt + 4'd1;
      end

      // Ack is only honoured while a transaction is outstanding; the ready
      // register doubles as the owner record for the single RESP cycle.
      if (in_busy && mem_ack) begin
        mem_req <= 1'b0;
        if (state == BUSY_I) begin
          imem_rd_data <= mem_rdata;
          imem_ready   <= 1'b1;
        end else begin
          if (!mem_we) dmem_r_data <= mem_rdata;
          dmem_ready <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SM = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] imem_rd_addr;
  logic          imem_rd_enable;
  logic [DW-1:0] imem_rd_data;
  logic          imem_ready;
  logic [AW-1:0] dmem_addr;
  logic          dmem_r_enable;
  logic          dmem_w_enable;
  logic [1:0]    dmem_w_size;
  logic [DW-1:0] dmem_w_data;
  logic [DW-1:0] dmem_r_data;
  logic          dmem_ready;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [1:0]    mem_size;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic          busy;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .clk(clk), .reset(reset),
    .imem_rd_addr(imem_rd_addr), .imem_rd_enable(imem_rd_enable),
    .imem_rd_data(imem_rd_data), .imem_ready(imem_ready),
    .dmem_addr(dmem_addr), .dmem_r_enable(dmem_r_enable),
    .dmem_w_enable(dmem_w_enable), .dmem_w_size(dmem_w_size),
    .dmem_w_data(dmem_w_data), .dmem_r_data(dmem_r_data),
    .dmem_ready(dmem_ready),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_size(mem_size), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- memory responder ----------------
  int   lat      = 1;
  bit   auto_ack = 1'b1;
  logic man_ack  = 1'b0;
  logic auto_ack_q = 1'b0;
  int   req_cyc  = 0;

  always @(negedge clk) begin
    if (auto_ack && mem_req) begin
      req_cyc    = req_cyc + 1;
      auto_ack_q = (req_cyc == lat);
    end else begin
      req_cyc    = 0;
      auto_ack_q = 1'b0;
    end
  end

  assign mem_ack   = auto_ack ? auto_ack_q : man_ack;
  assign mem_rdata = (mem_addr == 32'h100) ? 32'hDEADBEEF : ~mem_addr;

  // ---------------- behavioural model + compare ----------------
  int          m_phase = 0;   // 0 idle, 1 transaction outstanding, 2 response cycle
  int          m_own   = 0;   // 1 fetch, 2 data
  logic        m_req   = 0;
  logic [31:0] m_addr  = 0;
  logic        m_we    = 0;
  logic [1:0]  m_size  = 0;
  logic [31:0] m_wdata = 0;
  logic [31:0] m_irdata = 0;
  logic [31:0] m_drdata = 0;
  int          m_starve = 0;

  // transaction log and pulse counters for the directed expectations
  logic [31:0] log_addr[$];
  logic        log_we[$];
  int          log_st[$];
  int          imem_pulses = 0;
  int          dmem_pulses = 0;
  int          req_cycles  = 0;
  logic        prev_req    = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_phase = 0; m_own = 0; m_req = 0; m_addr = 0; m_we = 0; m_size = 0;
      m_wdata = 0; m_irdata = 0; m_drdata = 0; m_starve = 0;
    end else if (m_phase == 0) begin
      if ((dmem_r_enable || dmem_w_enable) && !(imem_rd_enable && m_starve == SM)) begin
        m_phase = 1; m_own = 2; m_req = 1;
        m_addr = dmem_addr; m_we = dmem_w_enable; m_size = dmem_w_size; m_wdata = dmem_w_data;
        m_starve = imem_rd_enable ? ((m_starve < SM) ? m_starve + 1 : SM) : 0;
      end else if (imem_rd_enable) begin
        m_phase = 1; m_own = 1; m_req = 1;
        m_addr = imem_rd_addr; m_we = 0; m_size = 2; m_wdata = 0;
        m_starve = 0;
      end
    end else if (m_phase == 1) begin
      if (mem_ack) begin
        m_req = 0; m_phase = 2;
        if (m_own == 1) m_irdata = mem_rdata;
        else if (!m_we) m_drdata = mem_rdata;
      end
    end else begin
      m_phase = 0;
    end

    #1;
    chk("mem_req",      mem_req,      m_req);
    chk("mem_addr",     mem_addr,     m_addr);
    chk("mem_we",       mem_we,       m_we);
    chk("mem_size",     mem_size,     m_size);
    chk("mem_wdata",    mem_wdata,    m_wdata);
    chk("imem_rd_data", imem_rd_data, m_irdata);
    chk("dmem_r_data",  dmem_r_data,  m_drdata);
    chk("imem_ready",   imem_ready,   (m_phase == 2 && m_own == 1));
    chk("dmem_ready",   dmem_ready,   (m_phase == 2 && m_own == 2));
    chk("busy",         busy,         (m_phase != 0));
    chk("starve_cnt",   dut.starve_cnt, m_starve);

    if (mem_req && !prev_req) begin
      log_addr.push_back(mem_addr);
      log_we.push_back(mem_we);
      log_st.push_back(int'(dut.starve_cnt));
    end
    prev_req    = mem_req;
    req_cycles  += int'(mem_req);
    imem_pulses += int'(imem_ready);
    dmem_pulses += int'(dmem_ready);
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_log();
    log_addr.delete(); log_we.delete(); log_st.delete();
    imem_pulses = 0; dmem_pulses = 0; req_cycles = 0;
  endtask

  task automatic wait_pulses(input int ni, input int nd, input string name);
    int n = 0;
    while ((imem_pulses < ni || dmem_pulses < nd) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL %s timeout: pulses i=%0d d=%0d required %0d/%0d",
               name, imem_pulses, dmem_pulses, ni, nd);
    end
  endtask

  logic [31:0] t4_addr [6];

  initial begin
    reset = 1; imem_rd_addr = 0; imem_rd_enable = 0; dmem_addr = 0;
    dmem_r_enable = 0; dmem_w_enable = 0; dmem_w_size = 0; dmem_w_data = 0;
    idle(3);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_imem_rd_data", imem_rd_data, 0);
    reset = 0;
    idle(2);

    // fetch only, ack in the second request cycle
    clear_log(); lat = 2;
    imem_rd_addr = 32'h100; imem_rd_enable = 1;
    wait_pulses(1, 0, "t1");
    imem_rd_enable = 0;
    idle(3);
    chk("t1_grants", log_addr.size(), 1);
    chk("t1_addr", log_addr[0], 32'h100);
    chk("t1_we", log_we[0], 0);
    chk("t1_req_cycles", req_cycles, 2);
    chk("t1_imem_pulses", imem_pulses, 1);
    chk("t1_dmem_pulses", dmem_pulses, 0);
    chk("t1_data", imem_rd_data, 32'hDEADBEEF);

    // simultaneous fetch and load: load first, then fetch
    clear_log(); lat = 1;
    imem_rd_addr = 32'h10; dmem_addr = 32'h40;
    imem_rd_enable = 1; dmem_r_enable = 1;
    wait_pulses(0, 1, "t3_load");
    dmem_r_enable = 0;
    wait_pulses(1, 1, "t3_fetch");
    imem_rd_enable = 0;
    idle(3);
    chk("t3_grants", log_addr.size(), 2);
    chk("t3_first_addr", log_addr[0], 32'h40);
    chk("t3_first_starve", log_st[0], 1);
    chk("t3_second_addr", log_addr[1], 32'h10);
    chk("t3_second_starve", log_st[1], 0);
    chk("t3_dmem_data", dmem_r_data, 32'hFFFFFFBF);
    chk("t3_imem_data", imem_rd_data, 32'hFFFFFFEF);

    // store, half-word
    clear_log(); lat = 2;
    dmem_addr = 32'h200; dmem_w_data = 32'h12345678; dmem_w_size = 2'd1; dmem_w_enable = 1;
    wait_pulses(0, 1, "t2");
    dmem_w_enable = 0;
    idle(3);
    chk("t2_grants", log_addr.size(), 1);
    chk("t2_we", log_we[0], 1);
    chk("t2_mem_size", mem_size, 1);
    chk("t2_mem_wdata", mem_wdata, 32'h12345678);
    chk("t2_dmem_pulses", dmem_pulses, 1);
    chk("t2_imem_pulses", imem_pulses, 0);
    chk("t2_dmem_r_data", dmem_r_data, 32'hFFFFFFBF);

    // starvation: both held, expect 4 data, 1 fetch, then data again
    clear_log(); lat = 1;
    imem_rd_addr = 32'h300; dmem_addr = 32'h400; dmem_w_size = 0;
    imem_rd_enable = 1; dmem_r_enable = 1;
    wait_pulses(1, 5, "t4");
    imem_rd_enable = 0; dmem_r_enable = 0;
    idle(3);
    t4_addr = '{32'h400, 32'h400, 32'h400, 32'h400, 32'h300, 32'h400};
    chk("t4_grants", log_addr.size(), 6);
    for (int i = 0; i < 6; i++) chk($sformatf("t4_addr%0d", i), log_addr[i], t4_addr[i]);
    chk("t4_starve_at_max", log_st[3], 4);
    chk("t4_starve_after_fetch", log_st[4], 0);

    // reset during a data transaction, then a stale ack
    clear_log(); auto_ack = 0;
    dmem_addr = 32'h500; dmem_r_enable = 1;
    idle(2);
    chk("t5_busy_before", busy, 1);
    reset = 1; dmem_r_enable = 0;
    idle(1);
    reset = 0;
    idle(2);
    man_ack = 1;
    idle(1);
    man_ack = 0;
    idle(3);
    auto_ack = 1;
    chk("t5_mem_req", mem_req, 0);
    chk("t5_busy", busy, 0);
    chk("t5_mem_addr", mem_addr, 0);
    chk("t5_dmem_pulses", dmem_pulses, 0);
    chk("t5_dmem_r_data", dmem_r_data, 0);

    // read and write together: a single write
    clear_log(); lat = 1;
    dmem_addr = 32'h600; dmem_w_data = 32'hA5A5A5A5; dmem_w_size = 2'd2;
    dmem_r_enable = 1; dmem_w_enable = 1;
    wait_pulses(0, 1, "t6");
    dmem_r_enable = 0; dmem_w_enable = 0;
    idle(3);
    chk("t6_grants", log_addr.size(), 1);
    chk("t6_we", log_we[0], 1);
    chk("t6_dmem_pulses", dmem_pulses, 1);
    chk("t6_mem_wdata", mem_wdata, 32'hA5A5A5A5);
    chk("t6_dmem_r_data", dmem_r_data, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
